// File: rtl/ice_uart_fifo_pkg.sv
// Shared constants for ice_uart_fifo: default register addresses, register
// selects, STATUS bit positions and FSM encodings.
package ice_uart_fifo_pkg;

  localparam logic [31:0] UART1_DATA_ADDR   = 32'h0300_0100;
  localparam logic [31:0] UART1_CLKDIV_ADDR = 32'h0300_0104;
  localparam logic [31:0] UART1_STATUS_ADDR = 32'h0300_0108;
  localparam logic [31:0] UART1_CTRL_ADDR   = 32'h0300_010C;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CLKDIV = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_OVF    = 5;
  localparam int ST_FRAME_ERR = 6;
  localparam int ST_TX_BUSY   = 7;
  localparam int ST_RX_COUNT  = 8;

  localparam logic [31:0] MIN_DIV = 32'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/ice_fifo_sync.sv
// Single-clock FIFO with first-word fall-through output; a push while full
// is accepted only when a pop happens in the same cycle.
module ice_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ice_uart_fifo.sv
// 8N1 UART with TX/RX FIFOs on the iomem bus. Define UART_IRQ_EN to get the
// CTRL register and the irq output; otherwise CTRL reads 0.
module ice_uart_fifo
  import ice_uart_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0100,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] io_memaddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_valid,
  output logic [31:0] io_rdata,
  output logic        io_ready,
  input  logic        ser_rx,
  output logic        ser_tx
`ifdef UART_IRQ_EN
  , output logic      irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, wr, rd;
  logic [1:0]    sel;
  logic [31:0]   clkdiv, div, status, rdata_nxt;
  logic          tx_ovf, rx_ovf, frame_err;
  logic [2:0]    flag_clr;
  logic          tx_push_req, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_ferr;
  logic [7:0]    rx_dout;
  logic [CW-1:0] rx_count;
  logic          unused_bits;

  assign hit = io_valid && (io_memaddr[31:4] == BASE_ADDR[31:4]) && !io_ready;
  assign wr  = hit && (io_wstrb != 4'h0);
  assign rd  = hit && (io_wstrb == 4'h0);
  assign sel = io_memaddr[3:2];
  assign div = eff_div(clkdiv);
  assign unused_bits = ^{io_memaddr[1:0], tx_count};

  assign tx_push_req = wr && (sel == REG_DATA) && io_wstrb[0];
  assign rx_pop      = rd && (sel == REG_DATA) && !rx_empty;
  assign flag_clr    = (wr && (sel == REG_STATUS) && io_wstrb[0]) ? io_wdata[6:4] : 3'b000;

  ice_fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(tx_push_req), .pop(tx_pop), .din(io_wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count));

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state, tx_state_nxt;
  logic [31:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic [7:0]  tx_sh, tx_sh_nxt;
  logic        ser_tx_nxt, tx_tc;

  assign tx_tc = (tx_cnt == 32'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      ser_tx   <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_sh    <= tx_sh_nxt;
      ser_tx   <= ser_tx_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_tc ? tx_cnt : tx_cnt - 32'd1;
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    ser_tx_nxt   = ser_tx;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_START: if (tx_tc) begin
        tx_state_nxt = TX_DATA;
        ser_tx_nxt   = tx_sh[0];
        tx_sh_nxt    = tx_sh >> 1;
        tx_bit_nxt   = 3'd0;
        tx_cnt_nxt   = div - 32'd1;
      end
      TX_DATA: if (tx_tc) begin
        tx_cnt_nxt = div - 32'd1;
        if (tx_bit == 3'd7) begin
          tx_state_nxt = TX_STOP;
          ser_tx_nxt   = 1'b1;
        end else begin
          tx_bit_nxt = tx_bit + 3'd1;
          ser_tx_nxt = tx_sh[0];
          tx_sh_nxt  = tx_sh >> 1;
        end
      end
      default: begin
        // IDLE, or the end of STOP: chain straight into the next frame
        if (tx_state == TX_IDLE || tx_tc) begin
          ser_tx_nxt   = 1'b1;
          tx_state_nxt = TX_IDLE;
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_sh_nxt    = tx_dout;
            ser_tx_nxt   = 1'b0;
            tx_cnt_nxt   = div - 32'd1;
            tx_state_nxt = TX_START;
          end
        end
      end
    endcase
  end

  // ---------------- RX FSM ----------------
  rx_state_t   rx_state, rx_state_nxt;
  logic [31:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_sh, rx_sh_nxt;
  logic        rx_s1, rx_s2, rx_s3, rx_tc;

  assign rx_tc = (rx_cnt == 32'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {ser_rx, rx_s1, rx_s2};
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_tc ? rx_cnt : rx_cnt - 32'd1;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_push      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_s3 && !rx_s2) begin
        rx_state_nxt = RX_START;
        rx_cnt_nxt   = (div >> 1) - 32'd1;
      end
      RX_START: if (rx_tc) begin
        rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        rx_bit_nxt   = 3'd0;
        rx_cnt_nxt   = div - 32'd1;
      end
      RX_DATA: if (rx_tc) begin
        rx_sh_nxt  = {rx_s2, rx_sh[7:1]};
        rx_cnt_nxt = div - 32'd1;
        rx_bit_nxt = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_tc) begin
        rx_push      = rx_s2;
        rx_ferr      = !rx_s2;
        rx_state_nxt = rx_s2 ? RX_IDLE : RX_BREAK;
      end
      default: if (rx_s2) rx_state_nxt = RX_IDLE;
    endcase
  end

  ice_fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(rx_push), .pop(rx_pop), .din(rx_sh),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count));

  // ---------------- registers and bus ----------------
`ifdef UART_IRQ_EN
  logic [2:0] ctrl;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ctrl <= 3'b000;
    else if (wr && (sel == REG_CTRL) && io_wstrb[0]) ctrl <= io_wdata[2:0];
  end
  assign irq = (ctrl[0] & !rx_empty) | (ctrl[1] & tx_empty) |
               (ctrl[2] & (tx_ovf | rx_ovf | frame_err));
`endif

  assign status = {15'h0, 9'(rx_count), (tx_state != TX_IDLE), frame_err, rx_ovf, tx_ovf,
                   rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rdata_nxt = 32'h0;
    case (sel)
      REG_DATA:   rdata_nxt = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_dout};
      REG_CLKDIV: rdata_nxt = clkdiv;
      REG_STATUS: rdata_nxt = status;
`ifdef UART_IRQ_EN
      default:    rdata_nxt = {29'h0, ctrl};
`else
      default:    rdata_nxt = 32'h0;
`endif
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      io_ready  <= 1'b0;
      io_rdata  <= '0;
      clkdiv    <= DEFAULT_DIV;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      io_ready <= hit;
      io_rdata <= rd ? rdata_nxt : 32'h0;
      if (wr && (sel == REG_CLKDIV))
        for (int b = 0; b < 4; b++)
          if (io_wstrb[b]) clkdiv[8*b +: 8] <= io_wdata[8*b +: 8];
      // a new event wins over a clear in the same cycle
      tx_ovf    <= (tx_ovf & ~flag_clr[0]) | (tx_push_req & tx_full & ~tx_pop);
      rx_ovf    <= (rx_ovf & ~flag_clr[1]) | (rx_push & rx_full & ~rx_pop);
      frame_err <= (frame_err & ~flag_clr[2]) | rx_ferr;
    end
  end

endmodule
